// File: rtl/reg_desl_iter_if.sv
// reg_desl_iter_if: request/result bundle between the control unit and the iterative shifter.
interface reg_desl_iter_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
);
  logic             Start;
  logic [1:0]       ContShifts;
  logic [1:0]       ShiftOp;
  logic [WIDTH-1:0] AFio;
  logic [WIDTH-1:0] BFio;
  logic [AMT_W-1:0] Shamt;
  logic [WIDTH-1:0] Result;
  logic [AMT_W-1:0] AmtOut;
  logic             Busy;
  logic             Done;
  modport master (
    output Start, ContShifts, ShiftOp, AFio, BFio, Shamt,
    input  Result, AmtOut, Busy, Done
  );
  modport slave (
    input  Start, ContShifts, ShiftOp, AFio, BFio, Shamt,
    output Result, AmtOut, Busy, Done
  );
endinterface

// File: rtl/reg_desl_iter.sv
// reg_desl_iter: sequential shifter, one bit per clock, amount chosen from four sources.
module reg_desl_iter #(
  parameter int WIDTH     = 32,
  parameter int AMT_W     = 5,
  parameter int CONST_AMT = 16
) (
  input logic           clk,
  input logic           reset,
  reg_desl_iter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           r_state;
  logic [AMT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic [AMT_W-1:0] r_amt;
  logic             r_busy;
  logic             r_done;
  logic [AMT_W-1:0] w_amt;
  logic [WIDTH-1:0] w_shifted;
  logic             w_unused;
  // Only the low AMT_W bits of BFio form the register-sourced amount.
  assign w_unused = ^bus.BFio[WIDTH-1:AMT_W];
  always_comb begin
    w_amt = bus.ContShifts == 2'b00 ? AMT_W'(CONST_AMT) :
            bus.ContShifts == 2'b01 ? bus.BFio[AMT_W-1:0] :
            bus.ContShifts == 2'b10 ? bus.Shamt : '0;
    w_shifted = r_op == 2'b00 ? {r_result[WIDTH-2:0], 1'b0} :
                r_op == 2'b01 ? {1'b0, r_result[WIDTH-1:1]} :
                r_op == 2'b10 ? {r_result[WIDTH-1], r_result[WIDTH-1:1]} :
                                {r_result[0], r_result[WIDTH-1:1]};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_amt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.Start) begin
          r_result <= bus.AFio;
          r_op     <= bus.ShiftOp;
          r_cnt    <= w_amt;
          r_amt    <= w_amt;
          r_busy   <= 1'b1;
          r_done   <= w_amt == '0;
          r_state  <= w_amt == '0 ? DONE : SHIFT;
        end
        SHIFT: begin
          r_result <= w_shifted;
          r_cnt    <= r_cnt - 1'b1;
          r_done   <= r_cnt == AMT_W'(1);
          r_state  <= r_cnt == AMT_W'(1) ? DONE : SHIFT;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign bus.Result = r_result;
  assign bus.AmtOut = r_amt;
  assign bus.Busy   = r_busy;
  assign bus.Done   = r_done;
endmodule

// File: tb/tb_reg_desl_iter.sv
// tb_reg_desl_iter: directed vector table plus hand-written multi-cycle sequences.
module tb_reg_desl_iter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  reg_desl_iter_if #(.WIDTH(32), .AMT_W(5)) bus ();
  reg_desl_iter #(.WIDTH(32), .AMT_W(5), .CONST_AMT(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  typedef struct {
    logic [1:0]  cs;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic [4:0]  amt;
  } vec_t;
  vec_t vt[11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    bus.ContShifts = v.cs;
    bus.ShiftOp    = v.op;
    bus.AFio       = v.a;
    bus.BFio       = v.b;
    bus.Shamt      = v.sh;
    bus.Start      = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    chk($sformatf("v%0d busy_at_accept", idx), 32'(bus.Busy), 32'd1);
    n = 0;
    while (!bus.Done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("v%0d done_latency", idx), 32'(n), 32'(v.amt));
    chk($sformatf("v%0d result", idx), bus.Result, v.res);
    chk($sformatf("v%0d amtout", idx), 32'(bus.AmtOut), 32'(v.amt));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d idle_busy_done", idx), {30'd0, bus.Busy, bus.Done}, 32'd0);
    chk($sformatf("v%0d result_hold", idx), bus.Result, v.res);
  endtask
  initial begin
    int n;
    vec_t v;
    bus.Start = 1'b0; bus.ContShifts = '0; bus.ShiftOp = '0;
    bus.AFio = '0; bus.BFio = '0; bus.Shamt = '0;
    vt[0]  = '{2'b00, 2'b00, 32'h0000ABCD, 32'h0,        5'd0,  32'hABCD0000, 5'd16};
    vt[1]  = '{2'b01, 2'b10, 32'h80000000, 32'hFFFFFFE4, 5'd0,  32'hF8000000, 5'd4};
    vt[2]  = '{2'b10, 2'b11, 32'h12345678, 32'h0,        5'd8,  32'h78123456, 5'd8};
    vt[3]  = '{2'b10, 2'b01, 32'h12345678, 32'h0,        5'd8,  32'h00123456, 5'd8};
    vt[4]  = '{2'b11, 2'b00, 32'hDEADBEEF, 32'hFFFFFFFF, 5'd7,  32'hDEADBEEF, 5'd0};
    vt[5]  = '{2'b10, 2'b00, 32'hDEADBEEF, 32'h0,        5'd0,  32'hDEADBEEF, 5'd0};
    vt[6]  = '{2'b10, 2'b10, 32'h80000000, 32'h0,        5'd31, 32'hFFFFFFFF, 5'd31};
    vt[7]  = '{2'b10, 2'b11, 32'h00000001, 32'h0,        5'd1,  32'h80000000, 5'd1};
    vt[8]  = '{2'b10, 2'b00, 32'h00000003, 32'h0,        5'd31, 32'h80000000, 5'd31};
    vt[9]  = '{2'b01, 2'b01, 32'h80000000, 32'hFFFFFF21, 5'd9,  32'h40000000, 5'd1};
    vt[10] = '{2'b01, 2'b10, 32'h7000000F, 32'h00000022, 5'd0,  32'h1C000003, 5'd2};
    #12;
    chk("reset_result", bus.Result, 32'h0);
    chk("reset_flags", {30'd0, bus.Busy, bus.Done}, 32'd0);
    chk("reset_amt", 32'(bus.AmtOut), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 11; i++) run(vt[i], i);
    // Start pulsed mid-operation must not disturb the running shift.
    @(negedge clk);
    bus.ContShifts = 2'b10; bus.ShiftOp = 2'b00; bus.Shamt = 5'd5;
    bus.AFio = 32'h1; bus.Start = 1'b1;
    @(posedge clk); #1; bus.Start = 1'b0;
    @(posedge clk);
    @(negedge clk); bus.Start = 1'b1; bus.AFio = 32'hFFFF; bus.Shamt = 5'd2;
    @(posedge clk); #1; bus.Start = 1'b0;
    n = 2;
    while (!bus.Done && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("ign_latency", 32'(n), 32'd5);
    chk("ign_result", bus.Result, 32'h20);
    chk("ign_amt", 32'(bus.AmtOut), 32'd5);
    @(posedge clk); #1;
    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    bus.ContShifts = 2'b10; bus.ShiftOp = 2'b01; bus.Shamt = 5'd10;
    bus.AFio = 32'hFFFFFFFF; bus.Start = 1'b1;
    @(posedge clk); #1; bus.Start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_result", bus.Result, 32'h0);
    chk("rst_flags", {30'd0, bus.Busy, bus.Done}, 32'd0);
    chk("rst_amt", 32'(bus.AmtOut), 32'd0);
    @(negedge clk); reset = 1'b0;
    v = '{2'b10, 2'b00, 32'h00000003, 32'h0, 5'd1, 32'h00000006, 5'd1};
    run(v, 99);
    // Start held high through DONE is only taken at the first IDLE edge.
    @(negedge clk);
    bus.ContShifts = 2'b11; bus.ShiftOp = 2'b00; bus.AFio = 32'h11; bus.Start = 1'b1;
    @(posedge clk); #1;
    chk("b2b_done0", {30'd0, bus.Busy, bus.Done}, 32'd3);
    chk("b2b_res0", bus.Result, 32'h11);
    bus.ContShifts = 2'b10; bus.Shamt = 5'd1; bus.AFio = 32'h22;
    @(posedge clk); #1;
    chk("b2b_idle", {30'd0, bus.Busy, bus.Done}, 32'd0);
    chk("b2b_idle_res", bus.Result, 32'h11);
    @(posedge clk); #1; bus.Start = 1'b0;
    chk("b2b_accept", {30'd0, bus.Busy, bus.Done}, 32'd2);
    @(posedge clk); #1;
    chk("b2b_done1", {30'd0, bus.Busy, bus.Done}, 32'd3);
    chk("b2b_res1", bus.Result, 32'h44);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_hold", bus.Result, 32'h44);
    chk("b2b_hold_flags", {30'd0, bus.Busy, bus.Done}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
